// File: rtl/mdio_master.sv
// MDIO management master: one command per valid/ready handshake, MDC derived from clk by CLK_DIV.
// Build option: define MDIO_CLAUSE45_EN to honour cmd_c45 (ST=00, all four C45 ops legal).
module mdio_master #(
    parameter int CLK_DIV = 10,
    parameter int PRE_LEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_c45,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_ack_err,
    output logic        eth_mdc,
    inout  wire         eth_mdio
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [5:0]    PRE_LAST = (PRE_LEN > 0) ? 6'(PRE_LEN - 1) : 6'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_STOP, S_ADDR, S_TA, S_DATA, S_END
    } state_t;

`ifdef MDIO_CLAUSE45_EN
    logic c45;
    assign c45 = cmd_c45;
`else
    logic c45;
    logic c45_unused;
    assign c45        = 1'b0;
    assign c45_unused = cmd_c45;
`endif

    logic        cmd_legal;
    logic [31:0] frame_w;

    // Clause 22 only knows write (01) and read (10).
    assign cmd_legal = c45 | (cmd_op[1] ^ cmd_op[0]);
    assign frame_w   = {1'b0, ~c45, cmd_op, cmd_phyad, cmd_regad, 2'b10, cmd_wdata};

    state_t          state_q, state_d, next_st;
    logic [DW-1:0]   div_q, div_d;
    logic [5:0]      bit_cnt_q, bit_cnt_d;
    logic [31:0]     tx_q, tx_d;
    logic [15:0]     rx_q, rx_d;
    logic            read_q, read_d;
    logic            ack_err_q, ack_err_d;
    logic            mdc_q, mdc_d;
    logic            mdo_q, mdo_d;
    logic            oe_q, oe_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_ack_err_q, rsp_ack_err_d;

    always_comb begin
        state_d       = state_q;
        next_st       = S_IDLE;
        div_d         = div_q;
        bit_cnt_d     = bit_cnt_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        read_d        = read_q;
        ack_err_d     = ack_err_q;
        mdo_d         = mdo_q;
        oe_d          = oe_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_ack_err_d = rsp_ack_err_q;

        if (state_q == S_IDLE) begin
            if (cmd_valid && cmd_ready_q) begin
                if (!cmd_legal) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = 16'hFFFF;
                    rsp_ack_err_d = 1'b1;
                end else begin
                    cmd_ready_d = 1'b0;
                    div_d       = '0;
                    read_d      = cmd_op[1];
                    ack_err_d   = 1'b0;
                    rx_d        = '0;
                    oe_d        = 1'b1;
                    if (PRE_LEN > 0) begin
                        state_d   = S_PRE;
                        bit_cnt_d = PRE_LAST;
                        mdo_d     = 1'b1;
                        tx_d      = frame_w;
                    end else begin
                        state_d   = S_STOP;
                        bit_cnt_d = 6'd3;
                        mdo_d     = frame_w[31];
                        tx_d      = {frame_w[30:0], 1'b0};
                    end
                end
            end
        end else begin
            // Sample on the first clock of MDC high.
            if (div_q == DIV_HALF) begin
                if (state_q == S_TA && bit_cnt_q == 6'd0)
                    ack_err_d = eth_mdio;
                if (state_q == S_DATA)
                    rx_d = {rx_q[14:0], eth_mdio};
            end
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (bit_cnt_q != 6'd0) begin
                    next_st   = state_q;
                    bit_cnt_d = bit_cnt_q - 6'd1;
                end else begin
                    case (state_q)
                        S_PRE:   begin next_st = S_STOP; bit_cnt_d = 6'd3;  end
                        S_STOP:  begin next_st = S_ADDR; bit_cnt_d = 6'd9;  end
                        S_ADDR:  begin next_st = S_TA;   bit_cnt_d = 6'd1;  end
                        S_TA:    begin next_st = S_DATA; bit_cnt_d = 6'd15; end
                        S_DATA:  begin next_st = S_END;  bit_cnt_d = 6'd0;  end
                        default: begin next_st = S_IDLE; bit_cnt_d = 6'd0;  end
                    endcase
                end
                state_d = next_st;
                case (next_st)
                    S_IDLE: begin
                        oe_d          = 1'b0;
                        mdo_d         = 1'b0;
                        cmd_ready_d   = 1'b1;
                        rsp_valid_d   = 1'b1;
                        rsp_ack_err_d = read_q & ack_err_q;
                        if (!read_q)
                            rsp_rdata_d = 16'h0000;
                        else if (ack_err_q)
                            rsp_rdata_d = 16'hFFFF;
                        else
                            rsp_rdata_d = rx_q;
                    end
                    S_PRE: begin
                        oe_d  = 1'b1;
                        mdo_d = 1'b1;
                    end
                    S_END: begin
                        oe_d  = 1'b0;
                        mdo_d = 1'b0;
                    end
                    default: begin
                        mdo_d = tx_q[31];
                        tx_d  = {tx_q[30:0], 1'b0};
                        oe_d  = !(read_q && (next_st == S_TA || next_st == S_DATA));
                    end
                endcase
            end else begin
                div_d = div_q + DW'(1);
            end
        end

        mdc_d = (state_d != S_IDLE) && (div_d >= DIV_HALF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            bit_cnt_q     <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
            read_q        <= 1'b0;
            ack_err_q     <= 1'b0;
            mdc_q         <= 1'b0;
            mdo_q         <= 1'b0;
            oe_q          <= 1'b0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_ack_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            read_q        <= read_d;
            ack_err_q     <= ack_err_d;
            mdc_q         <= mdc_d;
            mdo_q         <= mdo_d;
            oe_q          <= oe_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_ack_err_q <= rsp_ack_err_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_ack_err = rsp_ack_err_q;
    assign eth_mdc     = mdc_q;
    assign eth_mdio    = oe_q ? mdo_q : 1'bz;

endmodule
